raizing_video_timer: RTL and testbench
======================================

# raizing_video_timer

Parametrised raster timing generator for the Raizing video path. Produces pixel/line counters, blanking, sync, a one-line-ahead render line with screen-flip mirroring, and a raster-line interrupt. Sync windows and the interrupt line are runtime-programmable from the GCU register interface; sync changes take effect only at frame boundaries. Sits between the pixel-clock-enable source and the tilemap/sprite render and CRT output stages.

## Interface
Parameters:
- W, 9: counter and config data width.
- H_TOTAL, 432: pixels per line (including blanking).
- H_ACTIVE, 320: visible pixels per line.
- HS_START, 360: reset value of the HSYNC start pixel.
- HS_END, 379: reset value of the HSYNC end pixel (inclusive).
- V_TOTAL, 263: lines per frame.
- V_ACTIVE, 240: visible lines.
- VS_START, 244: reset value of the VSYNC start line.
- VS_END, 249: reset value of the VSYNC end line (inclusive).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous active-high reset.
- pxl_cen  in  1  pixel clock enable; counters advance only when high.
- flip  in  1  screen flip; mirrors vrender.
- cfg_we  in  1  config write strobe, one clk cycle.
- cfg_addr  in  3  0=hs_start, 1=hs_end, 2=vs_start, 3=vs_end, 4=irq_line; 5–7 ignored.
- cfg_din  in  W  config write data.
- irq_ack  in  1  clears irq.
- hpos  out  W  current pixel, 0..H_TOTAL-1.
- vpos  out  W  current line, 0..V_TOTAL-1.
- vrender  out  W  line being rendered (next line, flip-mapped).
- lhbl, lvbl  out  1 each  high during active pixels / lines.
- display_on  out  1  lhbl AND lvbl.
- hsync, vsync  out  1 each  active-high sync.
- irq  out  1  raster interrupt, level.

## Operation
- On a pxl_cen cycle, hpos increments. At H_TOTAL-1 it wraps to 0 and vpos increments; vpos wraps from V_TOTAL-1 to 0.
- No change to any state when pxl_cen=0, except config writes and irq_ack.
- Decodes: lhbl = hpos<H_ACTIVE; lvbl = vpos<V_ACTIVE.
- Sync window: hsync=1 when hs_start<=hpos<=hs_end. If start>end the window wraps: hpos>=start OR hpos<=end. vsync uses vpos with identical rules.
- vrender raw value r = vpos+1, with V_TOTAL-1 mapping to 0. If flip=1 and r<V_ACTIVE, vrender = V_ACTIVE-1-r; otherwise vrender = r. The flip is combinational on the registered r.
- Config writes to addresses 0–3 land in pending registers. Pending values copy to the active sync registers on the frame-wrap event, i.e. a pxl_cen cycle with hpos=H_TOTAL-1 and vpos=V_TOTAL-1.
- A write coinciding with frame-wrap is included in that commit.
- irq_line (address 4) takes effect immediately.
- irq sets on a pxl_cen cycle where the new counters are hpos=0 and vpos=irq_line. irq clears on irq_ack. If set and ack occur in the same cycle, set wins.
- irq_line >= V_TOTAL never fires.

## Timing
- All outputs are registered and reflect the post-increment counter values in the clk cycle after the pxl_cen edge. Decodes use next-state values, so outputs and counters never skew.
- Reset values: hpos=0, vpos=0, lhbl=1, lvbl=1, display_on=1, hsync=0, vsync=0, irq=0, irq_line=all ones.
- Pending and active sync registers reset to the HS_*/VS_* parameters.
- vrender after reset: 1, or V_ACTIVE-2 when flip=1.
- Reset asserted mid-frame returns everything to reset values on the next edge regardless of pxl_cen. Pending writes are discarded.
- A config write takes 1 clk to reach pending. A sync change is visible from the first pixel of the next frame.

## Structure
- Shared package raizing_video_pkg holds the cfg_addr encodings (CFG_HS_START..CFG_IRQ_LINE) and the default timing constants.
- Sub-module raizing_sync_window: a start/end/wrap comparator, instantiated twice (H and V).

## Test plan
- Reset, then pxl_cen every cycle → hpos wraps 431→0 with vpos 0→1. lhbl falls at hpos=320. hsync is high for hpos 360..379 (20 pixels). vsync is high for lines 244..249.
- pxl_cen every 4th cycle → counters hold between enables. Frame period is 4×432×263 clk.
- Write hs_start=325 and hs_end=380 at vpos=100 → current frame still uses 360..379. The next frame uses 325..380. A write landing exactly on the frame-wrap cycle is committed.
- Write hs_start=420, hs_end=10 → hsync is high for hpos 420..431 and 0..10.
- flip=1 → at vpos=0, vrender=238; at vpos=238, vrender=0; at vpos=240, vrender=241 (unmirrored); at vpos=262, vrender=0→mirrored 239.
- irq_line=16 → irq rises at vpos=16, hpos=0. Ack in the same cycle as a set keeps irq=1. irq_line=300 never fires. Reset mid-frame clears irq and counters.

Source files
------------

// File: rtl/raizing_video_pkg.sv
// Shared constants for the Raizing video timing path: config register map and
// the default raster geometry used by raizing_video_timer.
package raizing_video_pkg;

  localparam int DEF_W        = 9;
  localparam int DEF_H_TOTAL  = 432;
  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_HS_START = 360;
  localparam int DEF_HS_END   = 379;
  localparam int DEF_V_TOTAL  = 263;
  localparam int DEF_V_ACTIVE = 240;
  localparam int DEF_VS_START = 244;
  localparam int DEF_VS_END   = 249;

  // Register map of the GCU-side config port; codes 5..7 are ignored.
  typedef enum logic [2:0] {
    CFG_HS_START = 3'd0,
    CFG_HS_END   = 3'd1,
    CFG_VS_START = 3'd2,
    CFG_VS_END   = 3'd3,
    CFG_IRQ_LINE = 3'd4
  } cfg_addr_e;

endpackage

// File: rtl/raizing_video_timer_if.sv
// Config/interrupt-acknowledge bus between the GCU register block and the
// video timer. The GCU side drives everything; the timer only listens.
interface raizing_video_timer_if #(
  parameter int W = 9
);

  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [W-1:0] cfg_din;
  logic         irq_ack;

  modport master (output cfg_we, cfg_addr, cfg_din, irq_ack);
  modport slave  (input  cfg_we, cfg_addr, cfg_din, irq_ack);

endinterface

// File: rtl/raizing_sync_window.sv
// Inclusive start/end window comparator used for both HSYNC and VSYNC.
// When start > end the window wraps around the end of the line/frame.
module raizing_sync_window #(
  parameter int W = 9
) (
  input  logic [W-1:0] pos,
  input  logic [W-1:0] win_start,
  input  logic [W-1:0] win_end,
  output logic         hit
);

  logic ge_start;
  logic le_end;

  assign ge_start = (pos >= win_start);
  assign le_end   = (pos <= win_end);

  // Normal window needs both bounds; a wrapped window needs either one.
  assign hit = (win_start <= win_end) ? (ge_start && le_end) : (ge_start || le_end);

endmodule

// File: rtl/raizing_video_timer.sv
// Raster timing generator: pixel/line counters, blanking, programmable sync
// windows committed at frame wrap, one-line-ahead render line with flip
// mirroring, and a level raster interrupt. Every output is registered from the
// counters' next-state values so decodes and counters never skew.
module raizing_video_timer
  import raizing_video_pkg::*;
#(
  parameter int W        = DEF_W,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_END   = DEF_HS_END,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_END   = DEF_VS_END
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        pxl_cen,
  input  logic                        flip,
  raizing_video_timer_if.slave        cfg,
  output logic [W-1:0]                hpos,
  output logic [W-1:0]                vpos,
  output logic [W-1:0]                vrender,
  output logic                        lhbl,
  output logic                        lvbl,
  output logic                        display_on,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        irq
);

  // Counter next-state
  logic         h_wrap;
  logic         v_wrap;
  logic         frame_wrap;
  logic [W-1:0] h_nxt;
  logic [W-1:0] v_nxt;
  logic [W-1:0] r_nxt;
  logic [W-1:0] r_q;

  // Config registers: pending (written any time) and active (frame-committed)
  logic [W-1:0] hs_start_pend_q, hs_end_pend_q, vs_start_pend_q, vs_end_pend_q;
  logic [W-1:0] hs_start_pend_d, hs_end_pend_d, vs_start_pend_d, vs_end_pend_d;
  logic [W-1:0] hs_start_act_q,  hs_end_act_q,  vs_start_act_q,  vs_end_act_q;
  logic [W-1:0] hs_start_act_d,  hs_end_act_d,  vs_start_act_d,  vs_end_act_d;
  logic [W-1:0] irq_line_q, irq_line_d;

  logic hs_hit;
  logic vs_hit;
  logic irq_set;

  assign h_wrap     = (hpos == W'(H_TOTAL - 1));
  assign v_wrap     = (vpos == W'(V_TOTAL - 1));
  assign frame_wrap = pxl_cen && h_wrap && v_wrap;
  assign h_nxt      = h_wrap ? '0 : hpos + W'(1);
  assign v_nxt      = h_wrap ? (v_wrap ? '0 : vpos + W'(1)) : vpos;
  // Render runs one line ahead; the last line renders line 0 of the next frame.
  assign r_nxt      = (v_nxt == W'(V_TOTAL - 1)) ? '0 : v_nxt + W'(1);

  // Decode config writes into the pending set and the immediate irq line.
  // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    hs_start_pend_d = hs_start_pend_q;
    hs_end_pend_d   = hs_end_pend_q;
    vs_start_pend_d = vs_start_pend_q;
    vs_end_pend_d   = vs_end_pend_q;
    irq_line_d      = irq_line_q;
    if (cfg.cfg_we) begin
      case (cfg.cfg_addr)
        CFG_HS_START: hs_start_pend_d = cfg.cfg_din;
        CFG_HS_END:   hs_end_pend_d   = cfg.cfg_din;
        CFG_VS_START: vs_start_pend_d = cfg.cfg_din;
        CFG_VS_END:   vs_end_pend_d   = cfg.cfg_din;
        CFG_IRQ_LINE: irq_line_d      = cfg.cfg_din;
        default: ;
      endcase
    end
  end

  // Commit pending sync values at frame wrap, including a write landing that same cycle.
  assign hs_start_act_d = frame_wrap ? hs_start_pend_d : hs_start_act_q;
  assign hs_end_act_d   = frame_wrap ? hs_end_pend_d   : hs_end_act_q;
  assign vs_start_act_d = frame_wrap ? vs_start_pend_d : vs_start_act_q;
  assign vs_end_act_d   = frame_wrap ? vs_end_pend_d   : vs_end_act_q;

  raizing_sync_window #(.W(W)) u_hsync_win (
    .pos       (h_nxt),
    .win_start (hs_start_act_d),
    .win_end   (hs_end_act_d),
    .hit       (hs_hit)
  );

  raizing_sync_window #(.W(W)) u_vsync_win (
    .pos       (v_nxt),
    .win_start (vs_start_act_d),
    .win_end   (vs_end_act_d),
    .hit       (vs_hit)
  );

  // Config register file: pending sync set, active sync set and irq line.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_start_pend_q <= W'(HS_START);
      hs_end_pend_q   <= W'(HS_END);
      vs_start_pend_q <= W'(VS_START);
      vs_end_pend_q   <= W'(VS_END);
      hs_start_act_q  <= W'(HS_START);
      hs_end_act_q    <= W'(HS_END);
      vs_start_act_q  <= W'(VS_START);
      vs_end_act_q    <= W'(VS_END);
      irq_line_q      <= '1;
    end else begin
      hs_start_pend_q <= hs_start_pend_d;
      hs_end_pend_q   <= hs_end_pend_d;
      vs_start_pend_q <= vs_start_pend_d;
      vs_end_pend_q   <= vs_end_pend_d;
      hs_start_act_q  <= hs_start_act_d;
      hs_end_act_q    <= hs_end_act_d;
      vs_start_act_q  <= vs_start_act_d;
      vs_end_act_q    <= vs_end_act_d;
      irq_line_q      <= irq_line_d;
    end
  end

  // Counters and registered decodes, advancing only on pixel enables.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos       <= '0;
      vpos       <= '0;
      r_q        <= W'(1);
      lhbl       <= 1'b1;
      lvbl       <= 1'b1;
      display_on <= 1'b1;
      hsync      <= 1'b0;
      vsync      <= 1'b0;
    end else if (pxl_cen) begin
      hpos       <= h_nxt;
      vpos       <= v_nxt;
      r_q        <= r_nxt;
      lhbl       <= (h_nxt < W'(H_ACTIVE));
      lvbl       <= (v_nxt < W'(V_ACTIVE));
      display_on <= (h_nxt < W'(H_ACTIVE)) && (v_nxt < W'(V_ACTIVE));
      hsync      <= hs_hit;
      vsync      <= vs_hit;
    end
  end

  // Raster interrupt fires at the start of irq_line; a simultaneous ack loses.
  assign irq_set = pxl_cen && (h_nxt == '0) && (v_nxt == irq_line_q);

  // Level interrupt: set has priority over acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else if (irq_set) begin
      irq <= 1'b1;
    end else if (cfg.irq_ack) begin
      irq <= 1'b0;
    end
  end

  // Flip mirrors only visible render lines; blanking lines pass through.
  assign vrender = (flip && (r_q < W'(V_ACTIVE))) ? (W'(V_ACTIVE - 1) - r_q) : r_q;

endmodule

// File: tb/tb_raizing_video_timer.sv
// Directed bench for raizing_video_timer. A default-geometry instance covers
// the horizontal decodes of one line; a narrow-line instance (40 pixels per
// line, same vertical geometry) makes whole frames short enough to cover
// frame-wrap commits, flip mapping and the raster interrupt.
module tb_raizing_video_timer;

  localparam int S_HT = 40;
  localparam int VT   = 263;

  logic clk;
  logic reset;
  logic pxl_cen;
  logic flip;

  raizing_video_timer_if #(.W(9)) cfg_bus ();

  logic [8:0] d_hpos, d_vpos, d_vrender;
  logic       d_lhbl, d_lvbl, d_display_on, d_hsync, d_vsync, d_irq;
  logic [8:0] s_hpos, s_vpos, s_vrender;
  logic       s_lhbl, s_lvbl, s_display_on, s_hsync, s_vsync, s_irq;

  raizing_video_timer #(.W(9)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .pxl_cen    (pxl_cen),
    .flip       (flip),
    .cfg        (cfg_bus),
    .hpos       (d_hpos),
    .vpos       (d_vpos),
    .vrender    (d_vrender),
    .lhbl       (d_lhbl),
    .lvbl       (d_lvbl),
    .display_on (d_display_on),
    .hsync      (d_hsync),
    .vsync      (d_vsync),
    .irq        (d_irq)
  );

  raizing_video_timer #(
    .W(9), .H_TOTAL(S_HT), .H_ACTIVE(32), .HS_START(34), .HS_END(37)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .pxl_cen    (pxl_cen),
    .flip       (flip),
    .cfg        (cfg_bus),
    .hpos       (s_hpos),
    .vpos       (s_vpos),
    .vrender    (s_vrender),
    .lhbl       (s_lhbl),
    .lvbl       (s_lvbl),
    .display_on (s_display_on),
    .hsync      (s_hsync),
    .vsync      (s_vsync),
    .irq        (s_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int m_h   = 0;
  int m_v   = 0;
  int irq_seen = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One clk; tracks the narrow instance's raster position from the applied inputs.
  task automatic tick();
    logic en;
    logic rs;
    en = pxl_cen;
    rs = reset;
    @(posedge clk);
    #1;
    if (rs) begin
      m_h = 0;
      m_v = 0;
    end else if (en) begin
      if (m_h == S_HT - 1) begin
        m_h = 0;
        m_v = (m_v == VT - 1) ? 0 : m_v + 1;
      end else begin
        m_h++;
      end
    end
    if (s_irq) irq_seen++;
  endtask

  task automatic go_to(input int h, input int v);
    int guard;
    guard = 0;
    while (!(m_h == h && m_v == v) && guard < 20000) begin
      tick();
      guard++;
    end
    if (!(m_h == h && m_v == v)) check("goto_timeout", m_h * 1000 + m_v, h * 1000 + v);
  endtask

  task automatic wr(input logic [2:0] addr, input logic [8:0] din);
    cfg_bus.cfg_addr = addr;
    cfg_bus.cfg_din  = din;
    cfg_bus.cfg_we   = 1'b1;
    tick();
    cfg_bus.cfg_we   = 1'b0;
  endtask

  typedef struct {
    int k;
    int h;
    int v;
    bit lhbl;
    bit hs;
  } hvec_t;

  hvec_t hv[8];
  int    hs_cnt;
  int    cyc;
  int    c1;

  initial begin
    hv[0] = '{319, 319, 0, 1'b1, 1'b0};
    hv[1] = '{320, 320, 0, 1'b0, 1'b0};
    hv[2] = '{359, 359, 0, 1'b0, 1'b0};
    hv[3] = '{360, 360, 0, 1'b0, 1'b1};
    hv[4] = '{379, 379, 0, 1'b0, 1'b1};
    hv[5] = '{380, 380, 0, 1'b0, 1'b0};
    hv[6] = '{431, 431, 0, 1'b0, 1'b0};
    hv[7] = '{432,   0, 1, 1'b1, 1'b0};

    reset = 1'b1;
    pxl_cen = 1'b0;
    flip = 1'b0;
    cfg_bus.cfg_we = 1'b0;
    cfg_bus.cfg_addr = 3'd0;
    cfg_bus.cfg_din = 9'd0;
    cfg_bus.irq_ack = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_hpos", s_hpos, 0);
    check("rst_vpos", s_vpos, 0);
    check("rst_lhbl", s_lhbl, 1);
    check("rst_lvbl", s_lvbl, 1);
    check("rst_display_on", s_display_on, 1);
    check("rst_hsync", s_hsync, 0);
    check("rst_vsync", s_vsync, 0);
    check("rst_irq", s_irq, 0);
    check("rst_vrender", s_vrender, 1);
    check("rst_d_hpos", d_hpos, 0);
    check("rst_d_vrender", d_vrender, 1);
    flip = 1'b1;
    #1;
    check("rst_vrender_flip", s_vrender, 238);
    check("rst_d_vrender_flip", d_vrender, 238);
    flip = 1'b0;
    #1;

    // Default geometry: one full line with pxl_cen every cycle
    reset = 1'b0;
    pxl_cen = 1'b1;
    hs_cnt = 0;
    for (int k = 1; k <= 432; k++) begin
      tick();
      if (d_hsync) hs_cnt++;
      for (int i = 0; i < 8; i++) begin
        if (hv[i].k == k) begin
          check($sformatf("line_hpos_k%0d", k), d_hpos, hv[i].h);
          check($sformatf("line_vpos_k%0d", k), d_vpos, hv[i].v);
          check($sformatf("line_lhbl_k%0d", k), d_lhbl, hv[i].lhbl);
          check($sformatf("line_hsync_k%0d", k), d_hsync, hv[i].hs);
        end
      end
    end
    check("hsync_width", hs_cnt, 20);
    check("line1_vrender", d_vrender, 2);
    check("line1_display_on", d_display_on, 1);

    // Narrow-line instance from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_hpos", s_hpos, 0);

    // Frame 1: raster interrupt at line 16
    wr(3'd4, 9'd16);
    go_to(39, 15);
    check("irq_before_line", s_irq, 0);
    tick();
    check("irq_line_hpos", s_hpos, 0);
    check("irq_line_vpos", s_vpos, 16);
    check("irq_rise", s_irq, 1);
    cfg_bus.irq_ack = 1'b1;
    tick();
    cfg_bus.irq_ack = 1'b0;
    check("irq_ack_clear", s_irq, 0);

    // Frame 1: new hsync window written mid-frame stays pending
    go_to(0, 100);
    wr(3'd0, 9'd25);
    wr(3'd1, 9'd38);
    go_to(33, 101);
    check("pend_hs_33", s_hsync, 0);
    tick();
    check("pend_hs_34", s_hsync, 1);
    go_to(37, 101);
    check("pend_hs_37", s_hsync, 1);
    tick();
    check("pend_hs_38", s_hsync, 0);

    // Frame 1: flip mapping and vertical decodes
    go_to(0, 238);
    flip = 1'b1;
    #1;
    check("flip_v238", s_vrender, 0);
    flip = 1'b0;
    #1;
    check("noflip_v238", s_vrender, 239);
    go_to(39, 239);
    check("lvbl_239", s_lvbl, 1);
    tick();
    check("lvbl_240", s_lvbl, 0);
    check("display_on_240", s_display_on, 0);
    flip = 1'b1;
    #1;
    check("flip_v240", s_vrender, 241);
    flip = 1'b0;
    go_to(39, 243);
    check("vsync_243", s_vsync, 0);
    tick();
    check("vsync_244", s_vsync, 1);
    go_to(39, 249);
    check("vsync_249", s_vsync, 1);
    tick();
    check("vsync_250", s_vsync, 0);
    go_to(0, 262);
    flip = 1'b1;
    #1;
    check("flip_v262", s_vrender, 239);
    flip = 1'b0;
    #1;
    check("noflip_v262", s_vrender, 0);

    // Frame wrap and committed window 25..38
    go_to(39, 262);
    tick();
    check("wrap_hpos", s_hpos, 0);
    check("wrap_vpos", s_vpos, 0);
    check("wrap_lvbl", s_lvbl, 1);
    check("wrap_hsync", s_hsync, 0);
    go_to(24, 0);
    check("new_hs_24", s_hsync, 0);
    tick();
    check("new_hs_25", s_hsync, 1);
    go_to(38, 0);
    check("new_hs_38", s_hsync, 1);
    tick();
    check("new_hs_39", s_hsync, 0);

    // Frame 2: set and ack in the same cycle keeps irq
    go_to(39, 15);
    check("irq_pre_same", s_irq, 0);
    cfg_bus.irq_ack = 1'b1;
    tick();
    cfg_bus.irq_ack = 1'b0;
    check("irq_set_wins", s_irq, 1);
    cfg_bus.irq_ack = 1'b1;
    tick();
    cfg_bus.irq_ack = 1'b0;
    check("irq_ack2_clear", s_irq, 0);

    // Frame 2: wrapped window 36..3, start written on the wrap cycle itself
    go_to(0, 200);
    wr(3'd1, 9'd3);
    go_to(39, 262);
    wr(3'd0, 9'd36);
    check("wrapw_hs_0", s_hsync, 1);
    go_to(3, 0);
    check("wrapw_hs_3", s_hsync, 1);
    tick();
    check("wrapw_hs_4", s_hsync, 0);
    go_to(35, 0);
    check("wrapw_hs_35", s_hsync, 0);
    tick();
    check("wrapw_hs_36", s_hsync, 1);
    go_to(39, 0);
    check("wrapw_hs_39", s_hsync, 1);

    // Out-of-range irq line never fires across a whole frame
    go_to(0, 1);
    wr(3'd4, 9'd300);
    irq_seen = 0;
    go_to(0, 20);
    check("irq_300_silent", irq_seen, 0);

    // Mid-frame reset with pxl_cen low
    wr(3'd4, 9'd22);
    go_to(0, 22);
    check("irq22_rise", s_irq, 1);
    go_to(36, 22);
    check("pre_rst_hsync", s_hsync, 1);
    pxl_cen = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_hpos", s_hpos, 0);
    check("mid_rst_vpos", s_vpos, 0);
    check("mid_rst_irq", s_irq, 0);
    check("mid_rst_hsync", s_hsync, 0);
    check("mid_rst_lhbl", s_lhbl, 1);
    check("mid_rst_vrender", s_vrender, 1);

    // pxl_cen every 4th cycle: counters hold between enables
    pxl_cen = 1'b1;
    tick();
    check("cen4_first", s_hpos, 1);
    pxl_cen = 1'b0;
    tick();
    tick();
    tick();
    check("cen4_hold_h", s_hpos, 1);
    check("cen4_hold_v", s_vpos, 0);
    cyc = 4;
    while (!(s_hpos == 9'd0 && s_vpos == 9'd1) && cyc < 2000) begin
      pxl_cen = (cyc % 4 == 0);
      tick();
      cyc++;
    end
    check("cen4_first_line", cyc, 157);
    c1 = cyc;
    while (!(s_hpos == 9'd0 && s_vpos == 9'd2) && cyc < 2000) begin
      pxl_cen = (cyc % 4 == 0);
      tick();
      cyc++;
    end
    check("cen4_line_period", cyc - c1, 160);

    // Reset restored irq_line and the active hsync window
    pxl_cen = 1'b1;
    go_to(0, 22);
    check("rst_irq_line", s_irq, 0);
    go_to(34, 22);
    check("rst_hs_34", s_hsync, 1);
    go_to(38, 22);
    check("rst_hs_38", s_hsync, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
